// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared step-FSM states, display constants and source selects
package cpu_dbg_pkg;
    typedef enum logic [2:0] {IDLE, PRESS_WAIT, PULSE, HELD, RELEASE_WAIT} step_state_t;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF = 4'hF;
    localparam logic [1:0] SEL_PC = 2'b00;
    localparam logic [1:0] SEL_RS = 2'b01;
    localparam logic [1:0] SEL_RT = 2'b10;
    localparam logic [1:0] SEL_ALU = 2'b11;
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: 4-bit hex to active-low gfedcba segment pattern
module hex_to_seg7 (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    localparam logic [6:0] LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    assign seg = LUT[hex];
endmodule

// File: rtl/cpu_step_display.sv
// cpu_step_display: debounced single-step clock for the CPU plus 4-digit hex scan of a selected debug value
module cpu_step_display
    import cpu_dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES = 4,
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_btn,
    input  logic [1:0]  sel,
    input  logic [31:0] pc,
    input  logic [31:0] rs_out,
    input  logic [31:0] rt_out,
    input  logic [31:0] alu_out,
    output logic        cpu_clk,
    output logic [15:0] step_count,
    output logic [3:0]  an,
    output logic [7:0]  seg
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES > PULSE_CYCLES ? DEBOUNCE_CYCLES : PULSE_CYCLES);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);

    step_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0] step_count_n;
    logic btn_m, btn_s;
    logic [31:0] shadow, src;
    logic [SW-1:0] scan_cnt;
    logic [1:0] idx;
    logic [6:0] seg7;
    logic unused_hi;

    assign src = sel == SEL_PC ? pc : sel == SEL_RS ? rs_out : sel == SEL_RT ? rt_out : alu_out;
    assign unused_hi = ^shadow[31:16];

    hex_to_seg7 u_hex (.hex(shadow[{idx, 2'b00} +: 4]), .seg(seg7));

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        step_count_n = step_count;
        case (state)
            IDLE: if (btn_s) begin
                state_n = PRESS_WAIT;
                cnt_n = CW'(1);
            end
            PRESS_WAIT: if (!btn_s) state_n = IDLE;
            else if (cnt == D_LAST) begin
                state_n = PULSE;
                cnt_n = '0;
                step_count_n = step_count + 16'd1;
            end else cnt_n = cnt + 1'b1;
            PULSE: if (cnt == P_LAST) state_n = HELD;
            else cnt_n = cnt + 1'b1;
            HELD: if (!btn_s) begin
                state_n = RELEASE_WAIT;
                cnt_n = CW'(1);
            end
            RELEASE_WAIT: if (btn_s) state_n = HELD;
            else if (cnt == D_LAST) state_n = IDLE;
            else cnt_n = cnt + 1'b1;
            default: state_n = IDLE;
        endcase
    end

    // cpu_clk decodes the next state so it is high exactly while state==PULSE
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            state <= IDLE;
            cnt <= '0;
            step_count <= '0;
            cpu_clk <= 1'b0;
            shadow <= '0;
            scan_cnt <= '0;
            idx <= '0;
            an <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            btn_m <= step_btn;
            btn_s <= btn_m;
            state <= state_n;
            cnt <= cnt_n;
            step_count <= step_count_n;
            cpu_clk <= state_n == PULSE;
            if (state == IDLE || state == HELD) shadow <= src;
            scan_cnt <= scan_cnt == S_LAST ? '0 : scan_cnt + 1'b1;
            if (scan_cnt == S_LAST) idx <= idx + 2'd1;
            an <= ~(4'b0001 << idx);
            seg <= {1'b1, seg7};
        end
    end
endmodule

// File: tb/tb_cpu_step_display.sv
// tb_cpu_step_display: directed and random stimulus checked against a run-length reference model
module tb_cpu_step_display;
    localparam int D = 4;
    localparam int P = 2;
    localparam int S = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic step_btn = 1'b0;
    logic [1:0] sel = 2'b00;
    logic [31:0] pc = '0, rs_out = '0, rt_out = '0, alu_out = '0;
    logic cpu_clk;
    logic [15:0] step_count;
    logic [3:0] an;
    logic [7:0] seg;

    cpu_step_display #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .SCAN_DIV(S)) dut (
        .clk(clk), .rst(rst), .step_btn(step_btn), .sel(sel), .pc(pc), .rs_out(rs_out),
        .rt_out(rt_out), .alu_out(alu_out), .cpu_clk(cpu_clk), .step_count(step_count),
        .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model: phase 0 armed, 1 pulsing, 2 disarmed; run counts consecutive qualifying samples
    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    bit m_b1, m_b2;
    int phase, run, pleft, scnt, idx;
    logic [15:0] m_count;
    logic [31:0] m_shadow;
    logic m_cpu;
    logic [3:0] m_an;
    logic [7:0] m_seg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0] src;
        bit load;
        bit s;
        if (rst) begin
            m_b1 = 0; m_b2 = 0; phase = 0; run = 0; pleft = 0; scnt = 0; idx = 0;
            m_count = '0; m_shadow = '0; m_cpu = 0; m_an = 4'hF; m_seg = 8'hFF;
            return;
        end
        case (sel)
            2'b00: src = pc;
            2'b01: src = rs_out;
            2'b10: src = rt_out;
            default: src = alu_out;
        endcase
        load = phase != 1 && run == 0;
        s = m_b2;
        m_an = ~(4'b0001 << idx);
        m_seg = {1'b1, hex_tab[m_shadow[idx*4 +: 4]]};
        if (scnt == S - 1) begin
            scnt = 0;
            idx = (idx + 1) % 4;
        end else scnt++;
        if (load) m_shadow = src;
        if (phase == 0) begin
            run = s ? run + 1 : 0;
            if (run == D) begin
                phase = 1; pleft = P; run = 0; m_count = m_count + 16'd1;
            end
        end else if (phase == 1) begin
            pleft--;
            if (pleft == 0) begin
                phase = 2; run = 0;
            end
        end else begin
            run = !s ? run + 1 : 0;
            if (run == D) begin
                phase = 0; run = 0;
            end
        end
        m_cpu = phase == 1;
        m_b2 = m_b1;
        m_b1 = step_btn;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("cpu_clk", 32'(cpu_clk), 32'(m_cpu));
        chk("step_count", 32'(step_count), 32'(m_count));
        chk("an", 32'(an), 32'(m_an));
        chk("seg", 32'(seg), 32'(m_seg));
    endtask

    task automatic ticks(input int n, output int pulses);
        logic prev;
        pulses = 0;
        prev = cpu_clk;
        for (int i = 0; i < n; i++) begin
            tick();
            if (cpu_clk && !prev) pulses++;
            prev = cpu_clk;
        end
    endtask

    initial begin
        int first, high, np;
        logic [7:0] dig [4];
        logic [7:0] pat [7];
        bit seen;
        // reset
        rst = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_an", 32'(an), 32'h0000_000F);
        chk("rst_seg", 32'(seg), 32'h0000_00FF);
        rst = 0;
        tick();
        chk("first_digit_an", 32'(an), 32'b1110);
        ticks(5, np);
        // clean press: rise at the 6th edge after the first high sample, 2 cycles wide
        step_btn = 1;
        first = 0; high = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cpu_clk) begin
                high++;
                if (first == 0) first = i;
            end
        end
        chk("rise_edge", 32'(first), 32'd6);
        chk("pulse_width", 32'(high), 32'd2);
        chk("count_after_press", 32'(step_count), 32'd1);
        step_btn = 0;
        ticks(12, np);
        // press bounce, then release bounce
        pat = '{1, 1, 1, 0, 1, 1, 0};
        high = 0;
        for (int i = 0; i < 7; i++) begin
            step_btn = pat[i][0];
            tick();
            high += int'(cpu_clk);
        end
        ticks(2, np);
        chk("no_pulse_in_bounce", 32'(high + np), 32'd0);
        step_btn = 1;
        ticks(12, np);
        chk("one_pulse_after_bounce", 32'(np), 32'd1);
        step_btn = 0; tick(); step_btn = 1; tick(); step_btn = 0;
        ticks(12, np);
        chk("no_pulse_release", 32'(np), 32'd0);
        chk("count_after_bounce", 32'(step_count), 32'd2);
        // display scan of pc
        sel = 2'b00; pc = 32'h0000_1234;
        ticks(4, np);
        for (int i = 0; i < 12; i++) begin
            tick();
            for (int k = 0; k < 4; k++) if (an == ~(4'b0001 << k)) dig[k] = seg;
        end
        chk("pc_digit0", 32'(dig[0]), 32'b10011001);
        chk("pc_digit1", 32'(dig[1]), 32'b10110000);
        chk("pc_digit2", 32'(dig[2]), 32'b10100100);
        chk("pc_digit3", 32'(dig[3]), 32'b11111001);
        sel = 2'b11; alu_out = 32'hABCD_00EF;
        ticks(2, np);
        for (int i = 0; i < 12; i++) begin
            tick();
            for (int k = 0; k < 4; k++) if (an == ~(4'b0001 << k)) dig[k] = seg;
        end
        chk("alu_digit0", 32'(dig[0]), 32'b10001110);
        chk("alu_digit1", 32'(dig[1]), 32'b10000110);
        // shadow hold: pc changes mid-pulse, display follows only once HELD
        sel = 2'b00; pc = 32'h0000_5555;
        step_btn = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = cpu_clk;
        end
        chk("pulse_seen_hold", 32'(seen), 32'd1);
        pc = 32'h0000_9999;
        ticks(20, np);
        step_btn = 0;
        ticks(12, np);
        // step_count wrap
        force dut.step_count = 16'hFFFF;
        m_count = 16'hFFFF;
        tick();
        release dut.step_count;
        tick();
        step_btn = 1;
        ticks(12, np);
        chk("wrap_count", 32'(step_count), 32'd0);
        step_btn = 0;
        ticks(12, np);
        // reset mid-pulse
        step_btn = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = cpu_clk;
        end
        chk("pulse_seen_rst", 32'(seen), 32'd1);
        rst = 1; step_btn = 0;
        tick();
        chk("rst_mid_pulse", 32'(cpu_clk), 32'd0);
        rst = 0;
        ticks(14, np);
        chk("no_pulse_after_rst", 32'(np), 32'd0);
        // random stimulus
        for (int it = 0; it < 150; it++) begin
            step_btn = $urandom_range(0, 1) == 1;
            sel = 2'($urandom_range(0, 3));
            pc = $urandom; rs_out = $urandom; rt_out = $urandom; alu_out = $urandom;
            rst = $urandom_range(0, 24) == 0;
            tick();
            rst = 0;
            ticks($urandom_range(1, 12), np);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
